// File: rtl/bypass_scoreboard_pkg.sv
// Shared types for the bypass scoreboard: the per-stage entry record and the zero register.
package bypass_scoreboard_pkg;

    // Entry fields are sized to these ceilings so one typedef serves every
    // parametrisation; instances zero-extend their narrower AW/SW values.
    localparam int SB_AW_MAX = 8;
    localparam int SB_SW_MAX = 8;

    localparam logic [SB_AW_MAX-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                 valid;
        logic [SB_AW_MAX-1:0] waddr;
        logic [SB_SW_MAX-1:0] rdy_stage;
    } ScoreEntry;

endpackage

// File: rtl/bypass_port.sv
// One decode read port: youngest-match search over the scoreboard, ready check and operand select.
module bypass_port
    import bypass_scoreboard_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3
) (
    input  ScoreEntry [DEPTH-1:0] entries,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    input  logic [XLEN-1:0]       rf_rdata,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    output logic [XLEN-1:0]       rd_data,
    output logic                  not_ready
);

    logic                 hit;
    logic                 hit_rdy;
    logic [XLEN-1:0]      hit_data;
    logic [SB_AW_MAX-1:0] addr_ext;

    assign addr_ext = SB_AW_MAX'(rd_addr);

    // Scan oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rd_en && addr_ext != ZERO_REG && entries[k].valid &&
                entries[k].waddr == addr_ext) begin
                hit      = 1'b1;
                hit_rdy  = (entries[k].rdy_stage <= SB_SW_MAX'(k));
                hit_data = stage_data[k*XLEN +: XLEN];
            end
        end
    end

`ifdef BYPASS_EN
    assign not_ready = hit & ~hit_rdy;
    assign rd_data   = (hit && hit_rdy) ? hit_data : rf_rdata;
`else
    logic unused_fwd;
    assign unused_fwd = ^{hit_rdy, hit_data};
    // Without forwarding, the consumer waits until the producer has left writeback.
    assign not_ready  = hit;
    assign rd_data    = rf_rdata;
`endif

endmodule

// File: rtl/bypass_scoreboard.sv
// Operand-forwarding / hazard-tracking scoreboard between decode and writeback.
// Define BYPASS_EN for forwarding; otherwise any in-flight match stalls decode.
module bypass_scoreboard
    import bypass_scoreboard_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int NUM_READ = 2,
    parameter int SW       = $clog2(DEPTH),
    parameter int CW       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dec_valid,
    input  logic                     dec_wen,
    input  logic [AW-1:0]            dec_waddr,
    input  logic [SW-1:0]            dec_rdy_stage,
    input  logic [NUM_READ-1:0]      rd_en,
    input  logic [NUM_READ*AW-1:0]   rd_addr,
    input  logic [NUM_READ*XLEN-1:0] rf_rdata,
    input  logic [DEPTH*XLEN-1:0]    stage_data,
    input  logic                     freeze,
    input  logic [DEPTH-1:0]         kill,
    output logic [NUM_READ*XLEN-1:0] rd_data,
    output logic                     stall,
    output logic [SW:0]              inflight,
    output logic [CW-1:0]            stall_cnt
);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0] waddr_q, waddr_d;
    logic [DEPTH-1:0][SW-1:0] rdy_q, rdy_d;
    logic                     issue;
    logic [NUM_READ-1:0]      port_wait;
    ScoreEntry [DEPTH-1:0]    entries;

    function automatic logic [SW-1:0] clamp_stage(input logic [SW-1:0] s);
        if (int'(s) >= DEPTH) return SW'(DEPTH - 1);
        return s;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + CW'(1);
    endfunction

    assign issue = dec_valid & dec_wen & ~stall & ~freeze;

    // Kill is applied to the current entries before the shift, so a kill of
    // entry 0 never touches the instruction being issued this cycle.
    always_comb begin
        valid_d = valid_q & ~kill;
        waddr_d = waddr_q;
        rdy_d   = rdy_q;
        if (!freeze) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid_d[k] = valid_d[k-1];
                waddr_d[k] = waddr_d[k-1];
                rdy_d[k]   = rdy_d[k-1];
            end
            valid_d[0] = issue;
            waddr_d[0] = dec_waddr;
            rdy_d[0]   = clamp_stage(dec_rdy_stage);
        end
    end

    // Stage register: valid bits and the stall counter are control; tags are not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            stall_cnt <= '0;
        end else begin
            valid_q <= valid_d;
            if (stall && !freeze) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        rdy_q   <= rdy_d;
    end

    always_comb begin
        entries  = '0;
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries[k].valid     = valid_q[k];
            entries[k].waddr     = SB_AW_MAX'(waddr_q[k]);
            entries[k].rdy_stage = SB_SW_MAX'(rdy_q[k]);
            inflight             = inflight + (SW+1)'(valid_q[k]);
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        bypass_port #(
            .XLEN (XLEN),
            .AW   (AW),
            .DEPTH(DEPTH)
        ) u_port (
            .entries   (entries),
            .rd_en     (rd_en[i]),
            .rd_addr   (rd_addr[i*AW +: AW]),
            .rf_rdata  (rf_rdata[i*XLEN +: XLEN]),
            .stage_data(stage_data),
            .rd_data   (rd_data[i*XLEN +: XLEN]),
            .not_ready (port_wait[i])
        );
    end

    // A bubble in decode never needs to wait.
    assign stall = dec_valid & (|port_wait);

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard; expectations follow whether BYPASS_EN is defined.
module tb_bypass_scoreboard;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int SW    = 2;
    localparam int CW    = 4;

`ifdef BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] RF0 = 32'hAAAA_0001;
    localparam logic [31:0] RF1 = 32'hBBBB_0002;
    localparam logic [31:0] ALU = 32'h0000_1234;
    localparam logic [31:0] MEM = 32'h0000_CAFE;
    localparam logic [31:0] WB  = 32'h3333_3333;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 dec_valid;
    logic                 dec_wen;
    logic [AW-1:0]        dec_waddr;
    logic [SW-1:0]        dec_rdy_stage;
    logic [1:0]           rd_en;
    logic [2*AW-1:0]      rd_addr;
    logic [2*XLEN-1:0]    rf_rdata;
    logic [DEPTH*XLEN-1:0] stage_data;
    logic                 freeze;
    logic [DEPTH-1:0]     kill;
    logic [2*XLEN-1:0]    rd_data;
    logic                 stall;
    logic [SW:0]          inflight;
    logic [CW-1:0]        stall_cnt;

    typedef struct {
        string       tag;
        logic        stall;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [SW:0] infl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt;

    always #5 clk = ~clk;

    bypass_scoreboard #(
        .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NUM_READ(2), .SW(SW), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_wen(dec_wen), .dec_waddr(dec_waddr),
        .dec_rdy_stage(dec_rdy_stage),
        .rd_en(rd_en), .rd_addr(rd_addr), .rf_rdata(rf_rdata),
        .stage_data(stage_data), .freeze(freeze), .kill(kill),
        .rd_data(rd_data), .stall(stall), .inflight(inflight), .stall_cnt(stall_cnt)
    );

    task automatic check_field(input string tag, input string what,
                               input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    // Queue the expectation for this cycle, compare on the falling edge,
    // then advance past the next rising edge and track the stall counter.
    task automatic step(input string tag, input logic es, input logic [31:0] e0,
                        input logic [31:0] e1, input logic [SW:0] ei);
        exp_t e;
        e.tag = tag; e.stall = es; e.rd0 = e0; e.rd1 = e1; e.infl = ei; e.cnt = exp_cnt;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check_field(e.tag, "stall",     32'(stall),          32'(e.stall));
        check_field(e.tag, "rd_data0",  rd_data[31:0],       e.rd0);
        check_field(e.tag, "rd_data1",  rd_data[63:32],      e.rd1);
        check_field(e.tag, "inflight",  32'(inflight),       32'(e.infl));
        check_field(e.tag, "stall_cnt", 32'(stall_cnt),      32'(e.cnt));
        @(posedge clk);
        if (reset) exp_cnt = '0;
        else if (es && !freeze && exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [SW-1:0] r);
        dec_valid = v; dec_wen = w; dec_waddr = a; dec_rdy_stage = r;
    endtask

    task automatic set_rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en = en; rd_addr = {a1, a0};
    endtask

    task automatic drain();
        set_dec(1'b0, 1'b0, '0, '0);
        set_rd(2'b00, '0, '0);
        freeze = 1'b0;
        kill   = '0;
        repeat (DEPTH) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Producer issued, consumer immediately behind it on the given port.
    task automatic dep_pair(input string tag, input logic [AW-1:0] a, input logic [SW-1:0] r,
                            input int byp_wait, input logic [31:0] byp_data, input int port);
        int          n;
        logic [31:0] fwd;
        logic [31:0] want0;
        logic [31:0] want1;
        set_dec(1'b1, 1'b1, a, r);
        set_rd(2'b00, '0, '0);
        step({tag, "_issue"}, 1'b0, RF0, RF1, 3'd0);
        set_dec(1'b1, 1'b0, '0, '0);
        if (port == 0) set_rd(2'b01, a, '0);
        else           set_rd(2'b10, '0, a);
        n     = BYP ? byp_wait : DEPTH;
        fwd   = BYP ? byp_data : ((port == 0) ? RF0 : RF1);
        want0 = (port == 0) ? fwd : RF0;
        want1 = (port == 0) ? RF1 : fwd;
        for (int i = 0; i < n; i++) step({tag, "_wait"}, 1'b1, RF0, RF1, 3'd1);
        step({tag, "_fwd"}, 1'b0, want0, want1, BYP ? 3'd1 : 3'd0);
        drain();
    endtask

    initial begin
        logic nb;
        nb         = !BYP;
        exp_cnt    = '0;
        reset      = 1'b1;
        freeze     = 1'b0;
        kill       = '0;
        rf_rdata   = {RF1, RF0};
        stage_data = {WB, MEM, ALU};
        set_dec(1'b0, 1'b0, '0, '0);
        set_rd(2'b00, '0, '0);
        @(posedge clk);
        #1;
        step("reset", 1'b0, RF0, RF1, 3'd0);
        reset = 1'b0;

        dep_pair("alu",   5'd1,  2'd0, 0, ALU, 0);
        dep_pair("lduse", 5'd5,  2'd1, 1, MEM, 1);
        dep_pair("clamp", 5'd8,  2'd3, 2, WB,  0);

        // Writes to x0 never create a dependency.
        set_dec(1'b1, 1'b1, 5'd0, 2'd0);
        step("x0_issue", 1'b0, RF0, RF1, 3'd0);
        set_dec(1'b1, 1'b0, '0, '0);
        set_rd(2'b01, 5'd0, '0);
        rf_rdata = {RF1, 32'h0};
        step("x0_read", 1'b0, 32'h0, RF1, 3'd1);
        rf_rdata = {RF1, RF0};
        drain();

        // x3 written twice: youngest copy at stage 0 must win over stage 2.
        set_dec(1'b1, 1'b1, 5'd3, 2'd0);
        step("two_a", 1'b0, RF0, RF1, 3'd0);
        set_dec(1'b1, 1'b1, 5'd7, 2'd0);
        step("two_b", 1'b0, RF0, RF1, 3'd1);
        set_dec(1'b1, 1'b1, 5'd3, 2'd0);
        step("two_c", 1'b0, RF0, RF1, 3'd2);
        set_dec(1'b1, 1'b0, '0, '0);
        set_rd(2'b11, 5'd3, 5'd7);
        step("two_sel", nb, BYP ? ALU : RF0, BYP ? MEM : RF1, 3'd3);
        drain();

        // Freeze holds entries and the counter; kill still clears under freeze.
        set_dec(1'b1, 1'b1, 5'd2, 2'd0);
        step("frz_a", 1'b0, RF0, RF1, 3'd0);
        set_dec(1'b1, 1'b1, 5'd4, 2'd1);
        step("frz_b", 1'b0, RF0, RF1, 3'd1);
        set_dec(1'b1, 1'b0, '0, '0);
        set_rd(2'b01, 5'd4, '0);
        freeze = 1'b1;
        repeat (4) step("frz_hold", 1'b1, RF0, RF1, 3'd2);
        kill = 3'b011;
        step("frz_kill", 1'b1, RF0, RF1, 3'd2);
        kill   = '0;
        freeze = 1'b0;
        set_dec(1'b0, 1'b0, '0, '0);
        set_rd(2'b00, '0, '0);
        step("frz_after", 1'b0, RF0, RF1, 3'd0);
        drain();

        // kill[0] with a simultaneous issue drops only the older entry.
        set_dec(1'b1, 1'b1, 5'd6, 2'd0);
        step("kq_a", 1'b0, RF0, RF1, 3'd0);
        set_dec(1'b1, 1'b1, 5'd9, 2'd0);
        kill = 3'b001;
        step("kq_b", 1'b0, RF0, RF1, 3'd1);
        kill = '0;
        set_dec(1'b1, 1'b0, '0, '0);
        set_rd(2'b11, 5'd9, 5'd6);
        step("kq_read", nb, BYP ? ALU : RF0, RF1, 3'd1);
        drain();

        // Enough stall cycles to drive the narrow counter into saturation.
        repeat (8) dep_pair("sat", 5'd12, 2'd2, 2, WB, 0);

        // Reset in the middle of traffic, under freeze and kill.
        set_dec(1'b1, 1'b1, 5'd10, 2'd0);
        step("rm_a", 1'b0, RF0, RF1, 3'd0);
        set_dec(1'b1, 1'b1, 5'd11, 2'd0);
        step("rm_b", 1'b0, RF0, RF1, 3'd1);
        set_dec(1'b0, 1'b0, '0, '0);
        freeze = 1'b1;
        kill   = 3'b100;
        reset  = 1'b1;
        step("rm_assert", 1'b0, RF0, RF1, 3'd2);
        reset  = 1'b0;
        freeze = 1'b0;
        kill   = '0;
        set_dec(1'b1, 1'b0, '0, '0);
        set_rd(2'b01, 5'd10, '0);
        step("rm_after", 1'b0, RF0, RF1, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
